control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that drives the datapath control strobes for instruction fetch and register-to-register ALU execution. It replaces hand-sequenced control with a synchronous FSM stepping through T0..T6. It decodes the opcode and register fields from the IR and waits on a memory-done handshake during fetch. It sits between the IR/memory interface and the datapath control inputs.

## Interface
Parameters
- NREGS, 16, general register count; Rin/Rout are one-hot of this width; IR register fields are 4 bits.

Ports
- Clock  in  1  system clock, rising edge.
- Clear  in  1  synchronous, active-high reset.
- Run  in  1  level; permits starting and continuing the fetch/execute loop.
- Mdone  in  1  memory read complete; sampled in T1 only.
- IR  in  32  instruction register contents. Opcode is IR[31:27], Ra is IR[26:23], Rb is IR[22:19], Rc is IR[18:15].
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- Rout  out  NREGS  one-hot register-to-bus select.
- Rin  out  NREGS  one-hot register load enable.
- Alu_op  out  10  one-hot ALU select. Bit 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 MUL, 9 DIV.
- Running  out  1  high in T0..T6.
- Illegal  out  1  sticky illegal-opcode flag.

## Operation
- Opcode map:
  - 00000..00111: ADD, SUB, AND, OR, SHR, SHL, ROR, ROL (Alu_op bits 0..7).
  - 01000: MUL. 01001: DIV.
  - 11000: NOP. 11010: HALT.
  - All other opcodes are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED. Outputs are a Moore decode of the state plus the IR fields. Every strobe not listed for a state is 0.
- IDLE: no strobes. Goes to T0 when Run=1.
- T0: PCout, MARin, IncPC, Zin. Goes to T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while Mdone=0. Reloading PC from Z on each wait cycle is idempotent.
  - Goes to T2 on the edge where Mdone=1.
- T2: MDRout, IRin. Goes to T3. The IR is loaded on exit from T2, so decode happens in T3.
- T3, ALU/MUL/DIV opcode: Rout[Rb], Yin. Goes to T4.
- T3, NOP: no strobes. Goes to T0 if Run=1, else IDLE.
- T3, HALT: no strobes. Goes to HALTED.
- T3, illegal opcode: no strobes. Sets Illegal. Then behaves as NOP.
- T4: Rout[Rc], Alu_op[op], Zin. Goes to T5. For shifts and rotates, Rc supplies the count.
- T5, ALU opcode: Zlowout, Rin[Ra]. Goes to T0 if Run=1, else IDLE.
- T5, MUL/DIV: Zlowout, LOin. Goes to T6. Rin stays 0.
- T6: Zhighout, HIin. Goes to T0 if Run=1, else IDLE.
- HALTED: no strobes, Running=0. Ignores Run. Only Clear exits.
- Rin/Rout are decoded one-hot from the 4-bit fields; at most one bit of each is set.
- Clear while Running is low has the same effect as Clear in any other state.

## Timing
- Reset: Clear sampled high at a rising edge puts the FSM in IDLE. On the following cycle:
  - All strobes = 0; Rout = 0; Rin = 0; Alu_op = 0.
  - Running = 0; Illegal = 0.
- Clear has priority over every transition, including mid-instruction and in HALTED. Any in-flight instruction is abandoned with no further strobes.
- Latency with Mdone already high in T1:
  - ALU instruction: 6 cycles, T0..T5.
  - MUL/DIV: 7 cycles.
  - NOP/illegal/HALT: 4 cycles.
  - Each cycle that Mdone is low in T1 adds one cycle.
- Mdone is ignored outside T1. An Mdone pulse in another state is not remembered.
- Run is sampled only in IDLE and at instruction end (T3 for NOP/illegal, T5 for ALU, T6 for MUL/DIV). Dropping Run mid-instruction does not abort; the current instruction completes first.
- Illegal sets on the edge leaving T3 and holds until Clear.
- IR must be stable from the end of T2 through the last state of the instruction.

## Test plan
- OR: Clear, then Run=1, Mdone tied 1, IR=0x1A920000.
  - T0: PCout/MARin/IncPC/Zin.
  - T1: one cycle.
  - T3: Rout=0x0004 with Yin.
  - T4: Rout=0x0010, Alu_op=0x008, Zin.
  - T5: Zlowout, Rin=0x0020.
  - Next cycle is T0.
- Memory wait: Mdone held 0 for 3 cycles in T1 → Read/MDRin/PCin/Zlowout high for 4 cycles, then T2 → MDRout/IRin for exactly 1 cycle.
- MUL: IR=0x401A8000.
  - T3: Rout=0x0008.
  - T4: Rout=0x0020, Alu_op=0x100.
  - T5: Zlowout + LOin, Rin=0.
  - T6: Zhighout + HIin.
  - Total 7 cycles.
- HALT: IR=0xD0000000 → HALTED after T3, Running=0, no strobes for 20 cycles with Run=1. Clear → IDLE, then Run restarts at T0.
- Illegal: IR=0xF8000000 → no Rout/Yin in T3, Illegal=1 from next cycle, fetch restarts at T0. Illegal remains 1 until Clear.
- Clear mid-T4 of an OR instruction → next cycle IDLE, all outputs 0, no Rin pulse. Run=0 at T5 of an ALU instruction → IDLE, and T0 is not entered.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the IR/memory interface
// and datapath. The sequencer connects through the slave modport.
interface control_sequencer_if #(
    parameter int unsigned NREGS = 16
);
    logic             Run;
    logic             Mdone;
    logic [31:0]      IR;

    logic             PCout;
    logic             MARin;
    logic             IncPC;
    logic             Zin;
    logic             Zlowout;
    logic             Zhighout;
    logic             PCin;
    logic             Read;
    logic             MDRin;
    logic             MDRout;
    logic             IRin;
    logic             Yin;
    logic             HIin;
    logic             LOin;
    logic [NREGS-1:0] Rout;
    logic [NREGS-1:0] Rin;
    logic [9:0]       Alu_op;
    logic             Running;
    logic             Illegal;

    modport master (
        output Run, Mdone, IR,
        input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout,
        input  IRin, Yin, HIin, LOin, Rout, Rin, Alu_op, Running, Illegal
    );

    modport slave (
        input  Run, Mdone, IR,
        output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout,
        output IRin, Yin, HIin, LOin, Rout, Rin, Alu_op, Running, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: a T0..T6 Moore FSM that decodes the IR
// and drives the datapath strobes for register-to-register ALU, MUL and DIV.
module control_sequencer #(
    parameter int unsigned NREGS = 16
) (
    input  logic               Clock,
    input  logic               Clear,
    control_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalted
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_nop, is_halt, is_exec, is_illegal;
    logic [9:0] alu_sel;
    logic       unused_ir;

    assign opcode    = bus.IR[31:27];
    assign ra        = bus.IR[26:23];
    assign rb        = bus.IR[22:19];
    assign rc        = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    assign is_alu     = (opcode[4:3] == 2'b00);
    assign is_muldiv  = (opcode == 5'b01000) || (opcode == 5'b01001);
    assign is_nop     = (opcode == 5'b11000);
    assign is_halt    = (opcode == 5'b11010);
    assign is_exec    = is_alu || is_muldiv;
    assign is_illegal = !(is_exec || is_nop || is_halt);

    function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            v[i] = (32'(idx) == i);
        end
        return v;
    endfunction

    always_comb begin
        alu_sel = '0;
        if (is_alu) begin
            alu_sel[opcode[2:0]] = 1'b1;
        end else if (is_muldiv) begin
            if (opcode[0]) alu_sel[9] = 1'b1;
            else           alu_sel[8] = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q   <= StIdle;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Rout     = '0;
        bus.Rin      = '0;
        bus.Alu_op   = '0;
        bus.Running  = 1'b0;
        bus.Illegal  = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (bus.Run) state_d = StT0;
            end
            StT0: begin
                bus.Running = 1'b1;
                bus.PCout   = 1'b1;
                bus.MARin   = 1'b1;
                bus.IncPC   = 1'b1;
                bus.Zin     = 1'b1;
                state_d     = StT1;
            end
            StT1: begin
                // PC reload from Z repeats harmlessly while waiting on memory
                bus.Running = 1'b1;
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.Mdone) state_d = StT2;
            end
            StT2: begin
                bus.Running = 1'b1;
                bus.MDRout  = 1'b1;
                bus.IRin    = 1'b1;
                state_d     = StT3;
            end
            StT3: begin
                bus.Running = 1'b1;
                if (is_exec) begin
                    bus.Rout = onehot(rb);
                    bus.Yin  = 1'b1;
                    state_d  = StT4;
                end else if (is_halt) begin
                    state_d = StHalted;
                end else begin
                    if (is_illegal) illegal_d = 1'b1;
                    state_d = bus.Run ? StT0 : StIdle;
                end
            end
            StT4: begin
                bus.Running = 1'b1;
                bus.Rout    = onehot(rc);
                bus.Alu_op  = alu_sel;
                bus.Zin     = 1'b1;
                state_d     = StT5;
            end
            StT5: begin
                bus.Running = 1'b1;
                bus.Zlowout = 1'b1;
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                    state_d  = StT6;
                end else begin
                    bus.Rin = onehot(ra);
                    state_d = bus.Run ? StT0 : StIdle;
                end
            end
            StT6: begin
                bus.Running  = 1'b1;
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                state_d      = bus.Run ? StT0 : StIdle;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-exact bench for control_sequencer: per-instruction expected strobe
// sequences are queued from a vector table and compared cycle by cycle.
module tb_control_sequencer;
    localparam int unsigned NREGS = 16;

    // Strobe bit positions inside outs_t.strb
    localparam int P_PCOUT = 0, P_MARIN = 1, P_INCPC = 2, P_ZIN = 3, P_ZLO = 4, P_ZHI = 5;
    localparam int P_PCIN = 6, P_READ = 7, P_MDRIN = 8, P_MDROUT = 9, P_IRIN = 10;
    localparam int P_YIN = 11, P_HIIN = 12, P_LOIN = 13;

    localparam logic [13:0] S_T0  = 14'((1 << P_PCOUT) | (1 << P_MARIN) | (1 << P_INCPC) | (1 << P_ZIN));
    localparam logic [13:0] S_T1  = 14'((1 << P_ZLO) | (1 << P_PCIN) | (1 << P_READ) | (1 << P_MDRIN));
    localparam logic [13:0] S_T2  = 14'((1 << P_MDROUT) | (1 << P_IRIN));
    localparam logic [13:0] S_T3  = 14'(1 << P_YIN);
    localparam logic [13:0] S_T4  = 14'(1 << P_ZIN);
    localparam logic [13:0] S_T5A = 14'(1 << P_ZLO);
    localparam logic [13:0] S_T5M = 14'((1 << P_ZLO) | (1 << P_LOIN));
    localparam logic [13:0] S_T6  = 14'((1 << P_ZHI) | (1 << P_HIIN));

    localparam int C_ALU = 0, C_MD = 1, C_NOP = 2, C_ILL = 3, C_HALT = 4;

    typedef struct packed {
        logic [13:0] strb;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [9:0]  alu;
        logic        running;
        logic        illegal;
    } outs_t;

    typedef struct packed {
        outs_t exp;
        logic  mdone;
        logic  run;
        logic  clear;
    } chk_t;

    typedef struct {
        logic [31:0] ir;
        int          cls;
        int          waits;
        logic [15:0] rout3;
        logic [15:0] rout4;
        logic [15:0] rin;
        logic [9:0]  alu;
        bit          clr;
    } vec_t;

    logic  Clock = 1'b0;
    logic  Clear;
    outs_t act;
    chk_t  q[$];
    logic  ill_exp;
    int    n_checks = 0;
    int    n_errors = 0;
    string cur_test;
    vec_t  vecs[16];

    control_sequencer_if #(.NREGS(NREGS)) bus ();

    control_sequencer #(.NREGS(NREGS)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        act.strb    = {bus.LOin, bus.HIin, bus.Yin, bus.IRin, bus.MDRout, bus.MDRin, bus.Read,
                       bus.PCin, bus.Zhighout, bus.Zlowout, bus.Zin, bus.IncPC, bus.MARin,
                       bus.PCout};
        act.rout    = bus.Rout;
        act.rin     = bus.Rin;
        act.alu     = bus.Alu_op;
        act.running = bus.Running;
        act.illegal = bus.Illegal;
    end

    function automatic logic [31:0] mk_ir(input int unsigned op, input int unsigned ra,
                                          input int unsigned rb, input int unsigned rc);
        return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'b0};
    endfunction

    function automatic vec_t mkv(input logic [31:0] ir, input int cls, input int waits,
                                 input logic [15:0] r3, input logic [15:0] r4,
                                 input logic [15:0] rin, input logic [9:0] alu, input bit clr);
        vec_t v;
        v.ir = ir; v.cls = cls; v.waits = waits; v.rout3 = r3; v.rout4 = r4;
        v.rin = rin; v.alu = alu; v.clr = clr;
        return v;
    endfunction

    function automatic chk_t rec(input logic [13:0] s, input logic [15:0] ro,
                                 input logic [15:0] ri, input logic [9:0] al, input logic rn);
        chk_t c;
        c.exp.strb    = s;
        c.exp.rout    = ro;
        c.exp.rin     = ri;
        c.exp.alu     = al;
        c.exp.running = rn;
        c.exp.illegal = ill_exp;
        c.mdone       = 1'($urandom_range(0, 1)); // Mdone must be ignored outside T1
        c.run         = 1'b1;
        c.clear       = 1'b0;
        return c;
    endfunction

    task automatic push_instr(input vec_t v);
        chk_t c;
        q.push_back(rec(S_T0, '0, '0, '0, 1'b1));
        for (int i = 0; i < v.waits; i++) begin
            c = rec(S_T1, '0, '0, '0, 1'b1);
            c.mdone = 1'b0;
            q.push_back(c);
        end
        c = rec(S_T1, '0, '0, '0, 1'b1);
        c.mdone = 1'b1;
        q.push_back(c);
        q.push_back(rec(S_T2, '0, '0, '0, 1'b1));
        if (v.cls != C_ALU && v.cls != C_MD) begin
            q.push_back(rec('0, '0, '0, '0, 1'b1));
            if (v.cls == C_ILL) ill_exp = 1'b1;
            return;
        end
        q.push_back(rec(S_T3, v.rout3, '0, '0, 1'b1));
        q.push_back(rec(S_T4, v.rout4, '0, v.alu, 1'b1));
        if (v.cls == C_ALU) begin
            q.push_back(rec(S_T5A, '0, v.rin, '0, 1'b1));
        end else begin
            q.push_back(rec(S_T5M, '0, '0, '0, 1'b1));
            q.push_back(rec(S_T6, '0, '0, '0, 1'b1));
        end
    endtask

    task automatic drain();
        chk_t c;
        int   step;
        step = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            n_checks++;
            if (act !== c.exp) begin
                n_errors++;
                $display("FAIL %s step %0d: got %h expected %h", cur_test, step, act, c.exp);
            end
            bus.Mdone = c.mdone;
            bus.Run   = c.run;
            Clear     = c.clear;
            @(posedge Clock);
            #1;
            step++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(32'h1A92_0000, C_ALU, 0, 16'h0004, 16'h0010, 16'h0020, 10'h008, 0);
        vecs[1]  = mkv(32'h401A_8000, C_MD, 0, 16'h0008, 16'h0020, 16'h0000, 10'h100, 0);
        vecs[2]  = mkv(mk_ir(0, 15, 0, 9), C_ALU, 0, 16'h0001, 16'h0200, 16'h8000, 10'h001, 0);
        vecs[3]  = mkv(mk_ir(7, 1, 14, 7), C_ALU, 2, 16'h4000, 16'h0080, 16'h0002, 10'h080, 0);
        vecs[4]  = mkv(mk_ir(9, 3, 6, 12), C_MD, 0, 16'h0040, 16'h1000, 16'h0000, 10'h200, 0);
        vecs[5]  = mkv(mk_ir(1, 2, 4, 8), C_ALU, 3, 16'h0010, 16'h0100, 16'h0004, 10'h002, 0);
        vecs[6]  = mkv(32'hC000_0000, C_NOP, 1, '0, '0, '0, '0, 0);
        vecs[7]  = mkv(32'hF800_0000, C_ILL, 0, '0, '0, '0, '0, 0);
        vecs[8]  = mkv(mk_ir(4, 6, 5, 1), C_ALU, 0, 16'h0020, 16'h0002, 16'h0040, 10'h010, 0);
        vecs[9]  = mkv(32'h5000_0000, C_ILL, 0, '0, '0, '0, '0, 1);
        vecs[10] = mkv(32'hC800_0000, C_ILL, 2, '0, '0, '0, '0, 1);
        vecs[11] = mkv(mk_ir(2, 0, 15, 3), C_ALU, 1, 16'h8000, 16'h0008, 16'h0001, 10'h004, 0);
        vecs[12] = mkv(mk_ir(5, 9, 10, 11), C_ALU, 0, 16'h0400, 16'h0800, 16'h0200, 10'h020, 0);
        vecs[13] = mkv(mk_ir(6, 12, 13, 14), C_ALU, 0, 16'h2000, 16'h4000, 16'h1000, 10'h040, 0);
        vecs[14] = mkv(mk_ir(8, 7, 1, 2), C_MD, 1, 16'h0002, 16'h0004, 16'h0000, 10'h100, 0);
        vecs[15] = mkv(mk_ir(3, 11, 0, 0), C_ALU, 0, 16'h0001, 16'h0001, 16'h0800, 10'h008, 0);

        ill_exp   = 1'b0;
        Clear     = 1'b1;
        bus.Run   = 1'b0;
        bus.Mdone = 1'b0;
        bus.IR    = '0;
        repeat (2) @(posedge Clock);
        #1;
        Clear = 1'b0;

        cur_test = "reset";
        q.push_back(rec('0, '0, '0, '0, 1'b0));
        q[0].run = 1'b0;
        q.push_back(rec('0, '0, '0, '0, 1'b0));
        drain();

        for (int i = 0; i < 16; i++) begin
            cur_test = $sformatf("vec%0d ir=%h", i, vecs[i].ir);
            if (vecs[i].clr) begin
                Clear = 1'b1;
                @(posedge Clock);
                #1;
                Clear   = 1'b0;
                ill_exp = 1'b0;
                q.push_back(rec('0, '0, '0, '0, 1'b0));
                drain();
            end
            bus.IR = vecs[i].ir;
            push_instr(vecs[i]);
            drain();
        end

        // HALT parks the FSM regardless of Run; only Clear leaves, and it drops Illegal
        cur_test = "halt";
        bus.IR = 32'hD000_0000;
        push_instr(mkv(32'hD000_0000, C_HALT, 0, '0, '0, '0, '0, 0));
        for (int i = 0; i < 20; i++) q.push_back(rec('0, '0, '0, '0, 1'b0));
        q[q.size()-1].clear = 1'b1;
        ill_exp = 1'b0;
        q.push_back(rec('0, '0, '0, '0, 1'b0));
        drain();

        cur_test = "clear_mid_t4";
        bus.IR = vecs[0].ir;
        push_instr(vecs[0]);
        q.delete(5);
        q[4].clear = 1'b1;
        q.push_back(rec('0, '0, '0, '0, 1'b0));
        q[5].run = 1'b0;
        q.push_back(rec('0, '0, '0, '0, 1'b0));
        drain();

        // Run drops at T3: the instruction still completes, then the FSM idles
        cur_test = "run_drop";
        bus.IR = vecs[0].ir;
        push_instr(mkv(32'h1A92_0000, C_ALU, 1, 16'h0004, 16'h0010, 16'h0020, 10'h008, 0));
        for (int i = 4; i < 7; i++) q[i].run = 1'b0;
        q.push_back(rec('0, '0, '0, '0, 1'b0));
        q[7].run = 1'b0;
        q.push_back(rec('0, '0, '0, '0, 1'b0));
        q[8].run = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
